mux_rr_arbiter: RTL and testbench

Round-robin packet arbiter that shares one 2:1 data multiplexer (select 0 → source A, select 1 → source B) between two valid/ready requesters. It locks the mux onto one source for a whole packet, delimited by `last`, and presents the selected beat through a registered output stage. The block sits in front of any single shared downstream channel and keeps per-source packet counts for debug.

---
 rtl/mux_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin packet arbiter for two valid/ready sources that
// share one 2:1 data mux. The mux is locked to one source for a whole packet
// (delimited by last), and the selected beat goes through a registered output
// stage. Per-source completed-packet counters are kept for debug.
module mux_rr_arbiter #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          a_valid,
  input  logic          a_last,
  input  logic [W-1:0]  a_data,
  output logic          a_ready,

  input  logic          b_valid,
  input  logic          b_last,
  input  logic [W-1:0]  b_data,
  output logic          b_ready,

  output logic          out_valid,
  output logic          out_last,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,

  output logic          sel,
  output logic          busy,
  output logic [CW-1:0] pkt_cnt_a,
  output logic [CW-1:0] pkt_cnt_b
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t       state;
  logic         rr_last;   // last winner: 0 = A, 1 = B
  logic         slot_free; // output register can take a beat this cycle
  logic         a_xfer;
  logic         b_xfer;
  logic         load;
  logic [W-1:0] mux_data;
  logic         mux_last;

  // Readies depend only on lock state and the output register, never on valid
  always_comb begin
    slot_free = !out_valid || out_ready;
    a_ready   = (state == LOCK_A) && slot_free;
    b_ready   = (state == LOCK_B) && slot_free;
    a_xfer    = a_valid && a_ready;
    b_xfer    = b_valid && b_ready;
    load      = a_xfer || b_xfer;
  end

  // Shared 2:1 data mux steered by the registered select
  always_comb begin
    mux_data = sel ? b_data : a_data;
    mux_last = sel ? b_last : a_last;
  end

  // Arbitration FSM, output register and packet counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      sel       <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      pkt_cnt_a <= '0;
      pkt_cnt_b <= '0;
    end else begin
      // Data/last only change on a load, so they hold while stalled
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_last  <= mux_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // On a tie the source that did not win last time gets the lock
          if (a_valid && (!b_valid || rr_last)) begin
            state <= LOCK_A;
            sel   <= 1'b0;
            busy  <= 1'b1;
          end else if (b_valid) begin
            state <= LOCK_B;
            sel   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOCK_A: begin
          if (a_xfer && a_last) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rr_last   <= 1'b0;
            pkt_cnt_a <= pkt_cnt_a + CW'(1);
          end
        end
        LOCK_B: begin
          if (b_xfer && b_last) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rr_last   <= 1'b1;
            pkt_cnt_b <= pkt_cnt_b + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed testbench for mux_rr_arbiter. The DUT is built with CW = 2 so the
// packet counter wrap can be exercised in a few packets.
module tb_mux_rr_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst_n;
  logic          a_valid, a_last, a_ready;
  logic [W-1:0]  a_data;
  logic          b_valid, b_last, b_ready;
  logic [W-1:0]  b_data;
  logic          out_valid, out_last, out_ready;
  logic [W-1:0]  out_data;
  logic          sel, busy;
  logic [CW-1:0] pkt_cnt_a, pkt_cnt_b;

  mux_rr_arbiter #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_last    (a_last),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_last    (b_last),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .pkt_cnt_a (pkt_cnt_a),
    .pkt_cnt_b (pkt_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Source models: each source repeatedly offers packets of len beats,
  // data = base + beat index, last on the final beat.
  logic       a_en, b_en;
  logic [7:0] a_base, b_base;
  int         a_len, b_len, a_idx, b_idx;
  logic       acc_a, acc_b;
  logic [7:0] dq [$];   // beats consumed by the downstream
  logic [8:0] fair_exp [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    a_valid = a_en;
    a_data  = a_base + 8'(a_idx);
    a_last  = (a_idx == a_len - 1);
    b_valid = b_en;
    b_data  = b_base + 8'(b_idx);
    b_last  = (b_idx == b_len - 1);
  endtask

  // Apply inputs, note what transfers at the coming edge, then advance one
  // clock and return 1 time unit after the rising edge.
  task automatic step();
    drive();
    #1;
    acc_a = a_valid && a_ready;
    acc_b = b_valid && b_ready;
    if (out_valid && out_ready) dq.push_back(out_data);
    @(posedge clk);
    #1;
    if (acc_a) a_idx = (a_idx + 1 == a_len) ? 0 : a_idx + 1;
    if (acc_b) b_idx = (b_idx + 1 == b_len) ? 0 : b_idx + 1;
    drive();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    a_en  = 1'b0;
    b_en  = 1'b0;
    a_idx = 0;
    b_idx = 0;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    fair_exp = '{9'h000, 9'h1A0, 9'h1A1, 9'h1A2, 9'h000, 9'h1B0, 9'h1B1, 9'h1B2,
                 9'h000, 9'h1A0, 9'h1A1, 9'h1A2, 9'h000, 9'h1B0, 9'h1B1, 9'h1B2};
    rst_n = 1'b1; out_ready = 1'b1;
    a_en = 1'b0; b_en = 1'b0; a_idx = 0; b_idx = 0;
    a_base = 8'hAA; a_len = 1; b_base = 8'hBB; b_len = 1;
    drive();
    #1 rst_n = 1'b0;

    // Reset values with both sources requesting
    a_en = 1'b1; b_en = 1'b1;
    repeat (2) step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last",  32'(out_last),  0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_sel",       32'(sel),       0);
    check("rst_busy",      32'(busy),      0);
    check("rst_cnt_a",     32'(pkt_cnt_a), 0);
    check("rst_cnt_b",     32'(pkt_cnt_b), 0);
    check("rst_a_ready",   32'(a_ready),   0);
    check("rst_b_ready",   32'(b_ready),   0);

    // First tie after reset goes to A; next tie goes to B
    rst_n = 1'b1;
    step();
    check("first_busy",    32'(busy),    1);
    check("first_sel",     32'(sel),     0);
    check("first_a_ready", 32'(a_ready), 1);
    check("first_b_ready", 32'(b_ready), 0);
    step();
    check("first_out_data", 32'(out_data),  32'hAA);
    check("first_out_last", 32'(out_last),  1);
    check("first_cnt_a",    32'(pkt_cnt_a), 1);
    check("first_idle",     32'(busy),      0);
    step();
    check("second_sel",  32'(sel),  1);
    check("second_busy", 32'(busy), 1);

    // Fair tie-break with 3-beat packets from both sources
    reset_dut();
    a_base = 8'hA0; a_len = 3; b_base = 8'hB0; b_len = 3;
    a_en = 1'b1; b_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      check($sformatf("fair_valid_%0d", k + 1), 32'(out_valid), 32'(fair_exp[k][8]));
      if (fair_exp[k][8]) begin
        check($sformatf("fair_data_%0d", k + 1), 32'(out_data), 32'(fair_exp[k][7:0]));
        check($sformatf("fair_last_%0d", k + 1), 32'(out_last), 32'(fair_exp[k][3:0] == 4'h2));
      end
    end
    check("fair_cnt_a", 32'(pkt_cnt_a), 2);
    check("fair_cnt_b", 32'(pkt_cnt_b), 2);

    // Backpressure mid-packet on a 5-beat A packet 0x10..0x14
    reset_dut();
    a_base = 8'h10; a_len = 5; a_en = 1'b1; b_en = 1'b0;
    dq.delete();
    repeat (3) step();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("bp_data_%0d", k),  32'(out_data),  32'h11);
      check($sformatf("bp_valid_%0d", k), 32'(out_valid), 1);
      check($sformatf("bp_a_ready_%0d", k), 32'(a_ready), 0);
    end
    out_ready = 1'b1;
    repeat (4) step();
    check("bp_beat_count", dq.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < dq.size()) check($sformatf("bp_beat_%0d", k), 32'(dq[k]), 32'h10 + k);

    // Source bubble: A pauses mid-packet while B waits
    reset_dut();
    a_base = 8'h20; a_len = 2; b_base = 8'h30; b_len = 1;
    a_en = 1'b1; b_en = 1'b1;
    repeat (2) step();
    a_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bub_busy_%0d", k),    32'(busy),    1);
      check($sformatf("bub_sel_%0d", k),     32'(sel),     0);
      check($sformatf("bub_b_ready_%0d", k), 32'(b_ready), 0);
    end
    a_en = 1'b1;
    step();
    check("bub_last_data", 32'(out_data), 32'h21);
    check("bub_last_flag", 32'(out_last), 1);
    check("bub_idle",      32'(busy),     0);
    step();
    check("bub_b_sel",   32'(sel),     1);
    check("bub_b_busy",  32'(busy),    1);
    check("bub_b_ready", 32'(b_ready), 1);

    // Counter wrap with single-beat packets on B
    reset_dut();
    b_base = 8'h50; b_len = 1; a_en = 1'b0; b_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      step();
      check($sformatf("wrap_cnt_b_%0d", k), 32'(pkt_cnt_b), 32'((k + 1) % 4));
    end

    // Reset during beat 2 of a 4-beat A packet
    reset_dut();
    a_base = 8'h40; a_len = 4; b_base = 8'h60; b_len = 1;
    a_en = 1'b1; b_en = 1'b1;
    repeat (3) step();
    check("mid_beat2", 32'(out_data), 32'h41);
    rst_n = 1'b0;
    #1;
    check("mid_out_valid", 32'(out_valid), 0);
    check("mid_out_data",  32'(out_data),  0);
    check("mid_busy",      32'(busy),      0);
    check("mid_a_ready",   32'(a_ready),   0);
    check("mid_cnt_a",     32'(pkt_cnt_a), 0);
    a_idx = 0; b_idx = 0;
    step();
    rst_n = 1'b1;
    step();
    check("mid_regrant_busy",  32'(busy),    1);
    check("mid_regrant_sel",   32'(sel),     0);
    check("mid_regrant_ready", 32'(a_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
